// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t       : receiver FSM state encoding
//   CLKS_PER_BIT_DEF : default clk cycles per serial bit
//   FRAME_BITS       : data bits per frame (8N1)
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int unsigned CLKS_PER_BIT_DEF = 16;
  localparam int unsigned FRAME_BITS       = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO for the UART receiver.
//   clk, rst : clock, synchronous active-high reset (empties FIFO, clears storage)
//   push/din : write din when not full, or when full with a same-cycle pop
//   pop      : discard head entry; ignored when empty
//   dout     : storage at the read pointer (head byte while !empty)
//   empty    : no entries
//   full     : DEPTH entries
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty when indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot being written when full.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receiver with receive FIFO.
//   clk       : sole clock, rising edge
//   rst       : synchronous active-high reset
//   Rx        : asynchronous serial input, idle high, LSB first
//   rd_en     : pop FIFO head (ignored when ready=0)
//   data_out  : FIFO head byte, valid while ready=1
//   ready     : FIFO non-empty
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   overrun   : sticky; a received byte was dropped because the FIFO was full,
//               cleared by the next successful pop
//   busy      : receiver FSM not idle
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Rx,
  input  logic                  rd_en,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

  rx_state_t             state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n;
  logic                  sync1, rx_s, rx_d;
  logic                  push, ferr_n;
  logic                  fifo_empty, fifo_full;
  logic                  pop_ok, ovr_set;

  // Synchronizer plus one history flop for falling-edge detection on rx_s.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= Rx;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    push    = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        // Edge-triggered: a line held low after a frame never restarts.
        if (rx_d && !rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = DATA;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n        = '0;
          shreg_n[idx] = rx_s;
          idx_n        = idx + 1'b1;
          if (idx == LAST_IDX) begin
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) begin
            push = 1'b1;
          end else begin
            ferr_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign ready   = !fifo_empty;
  assign pop_ok  = rd_en && !fifo_empty;
  assign ovr_set = push && fifo_full && !pop_ok;

  // Set takes priority over the clear from a same-cycle pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (ovr_set) begin
      overrun <= 1'b1;
    end else if (pop_ok) begin
      overrun <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (rd_en),
    .din   (shreg_n),
    .dout  (data_out),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       Rx;
  logic       rd_en;
  logic [7:0] data_out;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  int edge_no = 0;
  int ferr_cnt = 0;
  int busy_cnt = 0;
  int last_ready_edge = 0;
  logic ready_q = 1'b0;
  int t0 = 0;

  uart_rx_ctrl #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Rx        (Rx),
    .rd_en     (rd_en),
    .data_out  (data_out),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_no <= edge_no + 1;

  always @(negedge clk) begin
    ready_q <= ready;
    if (ready && !ready_q) last_ready_edge <= edge_no;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a full frame starting at a negedge; returns one bit-period after the stop bit starts.
  task automatic send_frame(input logic [7:0] d, input logic s);
    Rx = 1'b0;
    t0 = edge_no + 1;
    wait_neg(CPB);
    for (int i = 0; i < 8; i++) begin
      Rx = d[i];
      wait_neg(CPB);
    end
    Rx = s;
    wait_neg(CPB);
  endtask

  task automatic pop1;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_ready;
    logic [7:0] exp_dout;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int   f0, b0, pe;
    logic hit;
    logic [7:0] exp_b;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
    vecs[3] = '{8'h96, 1'b0, 1'b0, 8'h00, 1};
    vecs[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 0};

    rst = 1'b1; Rx = 1'b1; rd_en = 1'b0;
    wait_neg(3);
    check("rst_data_out", {24'd0, data_out}, 32'h00);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    wait_neg(5);

    // Single-frame vectors
    for (int i = 0; i < 5; i++) begin
      f0 = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      Rx = 1'b1;
      check($sformatf("vec%0d_ready", i), {31'd0, ready}, {31'd0, vecs[i].exp_ready});
      if (vecs[i].exp_ready)
        check($sformatf("vec%0d_data", i), {24'd0, data_out}, {24'd0, vecs[i].exp_dout});
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      if (i == 0) check("latency", last_ready_edge - t0, 32'd154);
      if (ready) begin
        pop1();
        check($sformatf("vec%0d_ready_after_pop", i), {31'd0, ready}, 32'd0);
      end
      wait_neg(20);
    end

    // Short low glitch on idle line
    b0 = busy_cnt; f0 = ferr_cnt;
    Rx = 1'b0;
    wait_neg(8);
    Rx = 1'b1;
    wait_neg(30);
    check("glitch_busy_cycles", busy_cnt - b0, 32'd8);
    check("glitch_ready", {31'd0, ready}, 32'd0);
    check("glitch_ferr", ferr_cnt - f0, 32'd0);

    // Bad stop bit, line then held low: no restart
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    b0 = busy_cnt;
    wait_neg(100);
    check("heldlow_ferr_pulses", ferr_cnt - f0, 32'd1);
    check("heldlow_ready", {31'd0, ready}, 32'd0);
    check("heldlow_busy_cycles", busy_cnt - b0, 32'd0);
    Rx = 1'b1;
    wait_neg(20);
    send_frame(8'h11, 1'b1);
    check("after_ferr_data", {24'd0, data_out}, 32'h11);
    pop1();
    wait_neg(10);

    // Five back-to-back frames into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    wait_neg(5);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovr_ready%0d", i), {31'd0, ready}, 32'd1);
      check($sformatf("ovr_data%0d", i), {24'd0, data_out}, i);
      pop1();
      if (i == 1) check("ovr_clear_first_pop", {31'd0, overrun}, 32'd0);
    end
    check("ovr_empty", {31'd0, ready}, 32'd0);

    // Pop while empty is ignored
    rd_en = 1'b1;
    wait_neg(3);
    rd_en = 1'b0;
    check("pop_empty_ready", {31'd0, ready}, 32'd0);
    wait_neg(10);

    // Full FIFO with pop coinciding with the stop-bit push
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
    wait_neg(5);
    check("full_pre_ovr", {31'd0, overrun}, 32'd0);
    pe = edge_no + 155;
    hit = 1'b0;
    fork
      send_frame(8'h7E, 1'b1);
      begin
        for (int k = 0; k < 400 && edge_no != pe - 1; k++) @(negedge clk);
        hit = (edge_no == pe - 1);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    check("full_pop_aligned", {31'd0, hit}, 32'd1);
    check("full_pop_ovr", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      exp_b = (i == 3) ? 8'h7E : 8'h11 + 8'(i);
      check($sformatf("full_ready%0d", i), {31'd0, ready}, 32'd1);
      check($sformatf("full_data%0d", i), {24'd0, data_out}, {24'd0, exp_b});
      pop1();
    end
    check("full_empty", {31'd0, ready}, 32'd0);
    wait_neg(10);

    // Reset during data bit 4 of 0xFF, with a byte already queued
    send_frame(8'h22, 1'b1);
    check("pre_rst_ready", {31'd0, ready}, 32'd1);
    Rx = 1'b0;
    wait_neg(CPB);
    Rx = 1'b1;
    wait_neg(4 * CPB + 8);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_data", {24'd0, data_out}, 32'h00);
    check("midrst_ovr", {31'd0, overrun}, 32'd0);
    check("midrst_ferr", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    wait_neg(40);
    check("postrst_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h81, 1'b1);
    check("postrst_ready", {31'd0, ready}, 32'd1);
    check("postrst_data", {24'd0, data_out}, 32'h81);
    pop1();
    check("postrst_empty", {31'd0, ready}, 32'd0);
    wait_neg(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit (even, >=4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of 2).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port Rx  input  1  asynchronous serial line, idle high, 8N1 frames, LSB first.
REQ-006 SHALL have port rd_en  input  1  pop FIFO head when ready=1.
REQ-007 SHALL have port data_out  output  8  FIFO head byte, valid while ready=1.
REQ-008 SHALL have port ready  output  1  FIFO non-empty.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-010 SHALL have port overrun  output  1  sticky flag: byte dropped because FIFO was full.
REQ-011 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-012 SHALL pass Rx through a 2-flop synchronizer (rx_s); all decisions use rx_s only.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP with a bit-period counter and a 3-bit bit index.
REQ-014 IDLE: SHALL enter START, counter=0, only on a rx_s 1->0 transition (edge-based; a held-low line never re-triggers).
REQ-015 START: at counter=CLKS_PER_BIT/2-1, SHALL go to DATA if rx_s=0 (counter=0, index=0), else to IDLE (glitch rejected, no flags).
REQ-016 DATA: at counter=CLKS_PER_BIT-1, SHALL shift rx_s into bit[index], increment index, clear counter; after index 7 go to STOP.
REQ-017 STOP: at counter=CLKS_PER_BIT-1, SHALL push the byte if rx_s=1, else pulse frame_err and discard the byte; in both cases go to IDLE.
REQ-018 Latency: for CLKS_PER_BIT=16, ready SHALL rise 154 clk edges after the first edge at which the synchronizer samples Rx low (2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT).
REQ-019 Push when FIFO full and no simultaneous pop SHALL drop the byte and set overrun; FIFO contents are unchanged.
REQ-020 Push and pop in the same cycle when full SHALL both succeed with no overrun.
REQ-021 Pop when empty (rd_en=1, ready=0) SHALL be ignored.
REQ-022 Pop and push in the same cycle when empty SHALL be a push only; ready rises next cycle.
REQ-023 overrun SHALL clear on a successful pop, except when a new overrun occurs in the same cycle (set wins).
REQ-024 data_out SHALL be registered FIFO storage at the read pointer; pointers SHALL wrap modulo FIFO_DEPTH using an extra wrap bit for full/empty.

Reset
REQ-025 On rst=1, the FSM SHALL go to IDLE, counter/index=0, synchronizer flops=1, and the FIFO SHALL empty (pointers 0, storage 0).
REQ-026 Reset values SHALL be: data_out=8'h00, ready=0, frame_err=0, overrun=0, busy=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial byte; the next frame SHALL be received only after a fresh 1->0 edge.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state enum, the default CLKS_PER_BIT and the frame width constant (8).
REQ-029 The FIFO SHALL be a sub-module uart_rx_fifo (push, pop, din, dout, empty, full) instantiated once.

Verification
REQ-030 Frame 0x A5 at 16 clks/bit, stop=1 -> ready rises at edge 154; data_out=0xA5; rd_en pulse -> ready=0.
REQ-031 8-clk low glitch on idle Rx -> FSM returns to IDLE; no push, no frame_err; busy high for 8 cycles.
REQ-032 Frame 0x3C with stop=0, Rx then held low -> frame_err single pulse, FIFO empty, no restart until Rx goes high and falls again.
REQ-033 Five back-to-back frames 0x01..0x05, no reads -> FIFO holds 0x01..0x04, overrun=1; pops return 0x01..0x04 in order; overrun clears on the first pop.
REQ-034 rst asserted during DATA bit 4 of 0x FF -> outputs at reset values next cycle; the following frame 0x81 is received correctly.
REQ-035 FIFO full and rd_en=1 in the STOP push cycle -> 0x7E accepted, overrun stays 0, occupancy stays 4.
